biquad_seq: RTL

- Time-multiplexed direct-form-I second-order IIR section (biquad) with one shared signed multiplier and a wide accumulator.
- Computes y[n] = B0·x[n] + B1·x[n-1] + B2·x[n-2] − A1·y[n-1] − A2·y[n-2] once per input strobe.
- Sits directly upstream of the saturation stage. Its AW-bit output feeds the saturation block's wide input, which narrows it to the datapath width.

---
 rtl/biquad_seq_pkg.sv | 41 ++++
 rtl/biquad_seq_mac_unit.sv | 64 ++++++
 rtl/biquad_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/biquad_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : biquad_seq_pkg
// Description : Shared definitions for the time-multiplexed biquad section:
//               FSM state encoding, tap indices and constant functions for
//               accumulator width and the signed AW-range clamp limits (the
//               same limits are reused by the downstream saturation stage).
// Revision    : 1.0 - initial release
// ============================================================================
package biquad_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Taps 0..2 are feed-forward (added), taps 3..4 are feedback (subtracted).
  localparam logic [2:0] c_FIRST_FB_TAP = 3'd3;
  localparam logic [2:0] c_LAST_TAP     = 3'd4;

  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Five full-precision products plus the rounding constant cannot overflow
  // with three guard bits above the widest product.
  function automatic int acc_width(input int iw, input int aw, input int cw);
    return max_width(iw, aw) + cw + 3;
  endfunction

  function automatic longint sat_max(input int aw);
    return (longint'(1) <<< (aw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int aw);
    return -(longint'(1) <<< (aw - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/biquad_seq_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : biquad_seq_mac_unit
// Description : Shared signed multiplier feeding a wide accumulator.
//               load_i presets the accumulator to the round-half-up constant
//               2^(CF-1); add_i / sub_i add or subtract data_i * coef_i.
// Ports       : clk, reset_n      - clock, async active-low reset
//               load_i/add_i/sub_i - accumulator control (load has priority)
//               data_i, coef_i     - signed multiplicands
//               acc_o              - signed accumulator value
// Revision    : 1.0 - initial release
// ============================================================================
module biquad_seq_mac_unit #(
  parameter int DW    = 22,
  parameter int CW    = 18,
  parameter int CF    = 16,
  parameter int ACC_W = 43
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_i,
  input  logic                    add_i,
  input  logic                    sub_i,
  input  logic signed [DW-1:0]    data_i,
  input  logic signed [CW-1:0]    coef_i,
  output logic signed [ACC_W-1:0] acc_o
);

  localparam int PW = DW + CW;
  localparam logic signed [ACC_W-1:0] c_ROUND = ACC_W'(longint'(1) <<< (CF - 1));

  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  // Operands are widened to the product width first so the multiply is done
  // at full precision.
  assign w_prod     = PW'(data_i) * PW'(coef_i);
  assign w_prod_ext = ACC_W'(w_prod);

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = c_ROUND;
    end else if (add_i) begin
      acc_d = acc_q + w_prod_ext;
    end else if (sub_i) begin
      acc_d = acc_q - w_prod_ext;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/biquad_seq.sv
`default_nettype none
// ============================================================================
// Module      : biquad_seq
// Description : Direct-form-I biquad, one shared multiplier, one product per
//               cycle. Per accepted sample:
//               y = B0*x0 + B1*x1 + B2*x2 - A1*y1 - A2*y2 (coefs / 2^CF),
//               rounded half-up and clamped to the signed AW range.
// Ports       : clk, reset_n - clock, async active-low reset
//               ce_in, sig_in - input strobe and signed sample
//               ce_out        - one-cycle strobe with each new sig_out
//               sig_out       - signed result, held between strobes
//               clip          - result was clamped (pulses with ce_out)
//               overrun       - ce_in arrived while busy (sample dropped)
// Revision    : 1.0 - initial release
// ============================================================================
module biquad_seq
  import biquad_seq_pkg::*;
#(
  parameter int IW = 16,
  parameter int AW = 22,
  parameter int CW = 18,
  parameter int CF = 16,
  parameter int B0 = 65536,
  parameter int B1 = 0,
  parameter int B2 = 0,
  parameter int A1 = 0,
  parameter int A2 = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce_in,
  input  logic signed [IW-1:0] sig_in,
  output logic                 ce_out,
  output logic signed [AW-1:0] sig_out,
  output logic                 clip,
  output logic                 overrun
);

  localparam int DW    = max_width(IW, AW);
  localparam int ACC_W = acc_width(IW, AW, CW);

  localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'(sat_max(AW));
  localparam logic signed [ACC_W-1:0] c_SAT_MIN = ACC_W'(sat_min(AW));

  localparam logic signed [CW-1:0] c_B0 = CW'(B0);
  localparam logic signed [CW-1:0] c_B1 = CW'(B1);
  localparam logic signed [CW-1:0] c_B2 = CW'(B2);
  localparam logic signed [CW-1:0] c_A1 = CW'(A1);
  localparam logic signed [CW-1:0] c_A2 = CW'(A2);

  state_e                 state_q;
  logic [2:0]             tap_q;
  logic signed [IW-1:0]   x0_q, x1_q, x2_q;
  logic signed [AW-1:0]   y1_q, y2_q;
  logic signed [AW-1:0]   sig_q;
  logic                   ce_out_q, clip_q, overrun_q;

  logic signed [DW-1:0]    w_op;
  logic signed [CW-1:0]    w_coef;
  logic                    w_load, w_add, w_sub, w_in_mac;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] w_shift;
  logic signed [AW-1:0]    w_res;
  logic                    w_sat;

  // Operand / coefficient selection by tap index.
  always_comb begin
    w_op   = DW'(x0_q);
    w_coef = c_B0;
    case (tap_q)
      3'd0: begin w_op = DW'(x0_q); w_coef = c_B0; end
      3'd1: begin w_op = DW'(x1_q); w_coef = c_B1; end
      3'd2: begin w_op = DW'(x2_q); w_coef = c_B2; end
      3'd3: begin w_op = DW'(y1_q); w_coef = c_A1; end
      3'd4: begin w_op = DW'(y2_q); w_coef = c_A2; end
      default: ;
    endcase
  end

  assign w_in_mac = (state_q == ST_MAC);
  assign w_load   = (state_q == ST_IDLE) && ce_in;
  assign w_add    = w_in_mac && (tap_q < c_FIRST_FB_TAP);
  assign w_sub    = w_in_mac && (tap_q >= c_FIRST_FB_TAP);

  biquad_seq_mac_unit #(
    .DW    (DW),
    .CW    (CW),
    .CF    (CF),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (w_load),
    .add_i   (w_add),
    .sub_i   (w_sub),
    .data_i  (w_op),
    .coef_i  (w_coef),
    .acc_o   (w_acc)
  );

  // Arithmetic shift floors; with the 2^(CF-1) preload this rounds half-up.
  assign w_shift = w_acc >>> CF;

  always_comb begin
    w_sat = 1'b0;
    w_res = w_shift[AW-1:0];
    if (w_shift > c_SAT_MAX) begin
      w_res = c_SAT_MAX[AW-1:0];
      w_sat = 1'b1;
    end else if (w_shift < c_SAT_MIN) begin
      w_res = c_SAT_MIN[AW-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tap_q     <= 3'd0;
      x0_q      <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      sig_q     <= '0;
      ce_out_q  <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ce_out_q  <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ce_in) begin
            x0_q    <= sig_in;
            tap_q   <= 3'd0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          overrun_q <= ce_in;
          if (tap_q == c_LAST_TAP) begin
            state_q <= ST_OUT;
          end else begin
            tap_q <= tap_q + 3'd1;
          end
        end
        ST_OUT: begin
          overrun_q <= ce_in;
          sig_q     <= w_res;
          ce_out_q  <= 1'b1;
          clip_q    <= w_sat;
          x2_q      <= x1_q;
          x1_q      <= x0_q;
          y2_q      <= y1_q;
          // Feedback state takes the clamped value so it can never wrap.
          y1_q      <= w_res;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ce_out  = ce_out_q;
  assign sig_out = sig_q;
  assign clip    = clip_q;
  assign overrun = overrun_q;

endmodule
`default_nettype wire
